// File: rtl/pwm_pulse_capture.sv
`timescale 1ns/1ps
// Single-channel RC PWM capture: synchronises the pin and measures each high pulse in microseconds.
// Define PWM_GLITCH_FILTER_EN to insert a GLITCH_CYCLES stability filter ahead of edge detect.
module pwm_pulse_capture #(
    parameter int unsigned CLK_FREQ_HZ   = 100_000_000,
    parameter int unsigned MIN_PULSE_US  = 800,
    parameter int unsigned MAX_PULSE_US  = 2200,
    parameter int unsigned TIMEOUT_US    = 25000,
    parameter int unsigned GLITCH_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_pwm,
    output logic [15:0] o_pwm_value,
    output logic        o_pwm_ready,
    output logic        o_pwm_valid,
    output logic        o_pwm_err
);

    localparam int unsigned TICK_DIV      = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned PRESC_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CNT_W         = 16;
    localparam int unsigned SETTLE_CYCLES = 3 + GLITCH_CYCLES;
    localparam int unsigned SETTLE_W      = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        WAIT_LOW,
        WAIT_RISE,
        HIGH
    } state_t;

    logic [1:0]          sync_q;
    logic                lvl;
    logic                prev_q;
    logic                rise;
    logic                fall;
    logic [PRESC_W-1:0]  presc_q;
    logic                tick;
    logic [SETTLE_W-1:0] settle_q;
    logic                settled;
    state_t              state_q;
    state_t              state_nxt;
    logic [CNT_W-1:0]    width_q;
    logic [CNT_W-1:0]    width_nxt;
    logic [CNT_W-1:0]    width_inc;
    logic [CNT_W-1:0]    timeout_q;
    logic                accept;
    logic                reject;
    logic                expire;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], i_pwm};
        end
    end

`ifdef PWM_GLITCH_FILTER_EN
    localparam int unsigned GLITCH_W = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES + 1) : 1;

    logic                filt_q;
    logic [GLITCH_W-1:0] glitch_cnt_q;

    // Level follows the synchronised pin only after it has been stable long enough
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            filt_q       <= 1'b0;
            glitch_cnt_q <= '0;
        end else if (sync_q[1] == filt_q) begin
            glitch_cnt_q <= '0;
        end else if (glitch_cnt_q == GLITCH_W'(GLITCH_CYCLES - 1)) begin
            filt_q       <= sync_q[1];
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_q + GLITCH_W'(1);
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_q[1];
`endif

    assign rise    = lvl & ~prev_q;
    assign fall    = ~lvl & prev_q;
    assign tick    = (presc_q == PRESC_W'(TICK_DIV - 1));
    assign settled = (settle_q == SETTLE_W'(SETTLE_CYCLES));

    // Edge history, microsecond prescaler (re-phased on rise) and post-reset settle counter
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            prev_q   <= 1'b0;
            presc_q  <= '0;
            settle_q <= '0;
        end else begin
            prev_q <= lvl;
            if (rise || tick) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + PRESC_W'(1);
            end
            if (!settled) begin
                settle_q <= settle_q + SETTLE_W'(1);
            end
        end
    end

    assign width_inc = (tick && (width_q != '1)) ? width_q + CNT_W'(1) : width_q;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q <= WAIT_LOW;
            width_q <= '0;
        end else begin
            state_q <= state_nxt;
            width_q <= width_nxt;
        end
    end

    // WAIT_LOW is held until the synchroniser reflects the real pin, so a pulse already high
    // when reset releases is never mistaken for a fresh rise
    always_comb begin
        state_nxt = state_q;
        width_nxt = width_q;
        accept    = 1'b0;
        reject    = 1'b0;
        case (state_q)
            WAIT_LOW: begin
                if (settled && !lvl) begin
                    state_nxt = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (rise) begin
                    width_nxt = '0;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                width_nxt = width_inc;
                if (fall) begin
                    state_nxt = WAIT_RISE;
                    if ((width_inc >= CNT_W'(MIN_PULSE_US)) && (width_inc <= CNT_W'(MAX_PULSE_US))) begin
                        accept = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end else if (width_inc > CNT_W'(MAX_PULSE_US)) begin
                    reject    = 1'b1;
                    state_nxt = WAIT_LOW;
                end
            end
            default: state_nxt = WAIT_LOW;
        endcase
    end

    assign expire = tick && !accept && (timeout_q == CNT_W'(TIMEOUT_US - 1));

    // Loss-of-signal counter and registered outputs; an accepted pulse beats a same-cycle expiry
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            timeout_q   <= '0;
            o_pwm_value <= '0;
            o_pwm_ready <= 1'b0;
            o_pwm_valid <= 1'b0;
            o_pwm_err   <= 1'b0;
        end else begin
            o_pwm_ready <= accept;
            o_pwm_err   <= reject;
            if (accept) begin
                timeout_q <= '0;
            end else if (tick && (timeout_q != CNT_W'(TIMEOUT_US))) begin
                timeout_q <= timeout_q + CNT_W'(1);
            end
            if (accept) begin
                o_pwm_value <= width_inc;
                o_pwm_valid <= 1'b1;
            end else if (expire) begin
                o_pwm_value <= '0;
                o_pwm_valid <= 1'b0;
            end
        end
    end

endmodule
